// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_scoreboard
// Purpose  : ID-stage forwarding and hazard unit. A DEPTH-entry shift register
//            shadows the in-flight writers (entry 0 = EXE). Each ID source is
//            matched against it, the youngest match is selected, and load-use
//            or no-forward RAW hazards raise a stall.
// Ports    : clk_i, rst_ni          clock, synchronous active-low reset
//            fwd_en_i               1 = forward, 0 = stall on every RAW hazard
//            id_*_i, flush_i        ID instruction description / kill
//            rf_val1_i, rf_val2_i   register-file operands
//            stage_data_i           stage i result at [i*DATA_W +: DATA_W]
//            val1_o, val2_o         resolved operands
//            val1_sel_o, val2_sel_o 0 = register file, i+1 = stage i
//            stall_o                hold PC and IF/ID, bubble into EXE
//            stall_count_o          saturating stall-cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    fwd_en_i,
  input  logic                    id_valid_i,
  input  logic [ADDR_W-1:0]       id_src1_i,
  input  logic [ADDR_W-1:0]       id_src2_i,
  input  logic                    id_uses_src2_i,
  input  logic [ADDR_W-1:0]       id_dest_i,
  input  logic                    id_wb_en_i,
  input  logic                    id_is_load_i,
  input  logic                    flush_i,
  input  logic [DATA_W-1:0]       rf_val1_i,
  input  logic [DATA_W-1:0]       rf_val2_i,
  input  logic [DEPTH*DATA_W-1:0] stage_data_i,
  output logic [DATA_W-1:0]       val1_o,
  output logic [DATA_W-1:0]       val2_o,
  output logic [SEL_W-1:0]        val1_sel_o,
  output logic [SEL_W-1:0]        val2_sel_o,
  output logic                    stall_o,
  output logic [15:0]             stall_count_o
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  logic              sb_wb_q   [DEPTH];
  logic [ADDR_W-1:0] sb_dest_q [DEPTH];
  logic              sb_load_q [DEPTH];
  logic [15:0]       cnt_q, cnt_d;
  logic              push_d;

  // Lookup results per source: hit, selected stage, stage data, load-use flag
  logic              hit1, hit2;
  logic [SEL_W-1:0]  sel1, sel2;
  logic [DATA_W-1:0] data1, data2;
  logic              lu1, lu2;
  logic              haz1, haz2;

  // Scan from oldest to youngest so the youngest match is the last write
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    sel1  = '0;
    sel2  = '0;
    data1 = '0;
    data2 = '0;
    lu1   = 1'b0;
    lu2   = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((id_src1_i != '0) && sb_wb_q[i] && (sb_dest_q[i] == id_src1_i)) begin
        hit1  = 1'b1;
        sel1  = SEL_W'(i + 1);
        data1 = stage_data_i[i*DATA_W +: DATA_W];
        lu1   = sb_load_q[i] && (i < LOAD_LAT);
      end
      if ((id_src2_i != '0) && sb_wb_q[i] && (sb_dest_q[i] == id_src2_i)) begin
        hit2  = 1'b1;
        sel2  = SEL_W'(i + 1);
        data2 = stage_data_i[i*DATA_W +: DATA_W];
        lu2   = sb_load_q[i] && (i < LOAD_LAT);
      end
    end
  end

  // Without forwarding every match is a hazard; with it only unready loads
  assign haz1 = hit1 && (fwd_en_i ? lu1 : 1'b1);
  assign haz2 = id_uses_src2_i && hit2 && (fwd_en_i ? lu2 : 1'b1);

  assign stall_o = rst_ni && id_valid_i && !flush_i && (haz1 || haz2);

  // A source forwards only when its youngest match is usable right now
  always_comb begin
    val1_sel_o = '0;
    val2_sel_o = '0;
    val1_o     = rf_val1_i;
    val2_o     = rf_val2_i;
    if (rst_ni && fwd_en_i) begin
      if (hit1 && !lu1) begin
        val1_sel_o = sel1;
        val1_o     = data1;
      end
      if (id_uses_src2_i && hit2 && !lu2) begin
        val2_sel_o = sel2;
        val2_o     = data2;
      end
    end
  end

  assign push_d = id_valid_i && !stall_o && !flush_i && id_wb_en_i;
  assign cnt_d  = (stall_o && (cnt_q != C_CNT_MAX)) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_wb_q[i]   <= 1'b0;
        sb_dest_q[i] <= '0;
        sb_load_q[i] <= 1'b0;
      end
      cnt_q <= '0;
    end else begin
      sb_wb_q[0]   <= push_d;
      sb_dest_q[0] <= id_dest_i;
      sb_load_q[0] <= id_is_load_i;
      for (int i = 1; i < DEPTH; i++) begin
        sb_wb_q[i]   <= sb_wb_q[i-1];
        sb_dest_q[i] <= sb_dest_q[i-1];
        sb_load_q[i] <= sb_load_q[i-1];
      end
      cnt_q <= cnt_d;
    end
  end

  assign stall_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_scoreboard
// Purpose  : Directed cycle-by-cycle vectors for a DEPTH=3 instance plus a
//            long stall run on a DEPTH=7 instance for counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_scoreboard;

  localparam int C_DA = 3;
  localparam int C_DB = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (DEPTH=3) ----------------
  logic        rn, fwd, vld, u2, wb, ld, fl;
  logic [4:0]  s1, s2, dst;
  logic [31:0] rf1, rf2;
  logic [C_DA*32-1:0] sd_a;
  logic [31:0] v1, v2;
  logic [2:0]  sel1, sel2;
  logic        st;
  logic [15:0] cnt;

  fwd_hazard_scoreboard #(.ADDR_W(5), .DATA_W(32), .DEPTH(C_DA), .LOAD_LAT(1), .SEL_W(3)) u_dut_a (
    .clk_i(clk), .rst_ni(rn), .fwd_en_i(fwd), .id_valid_i(vld),
    .id_src1_i(s1), .id_src2_i(s2), .id_uses_src2_i(u2), .id_dest_i(dst),
    .id_wb_en_i(wb), .id_is_load_i(ld), .flush_i(fl),
    .rf_val1_i(rf1), .rf_val2_i(rf2), .stage_data_i(sd_a),
    .val1_o(v1), .val2_o(v2), .val1_sel_o(sel1), .val2_sel_o(sel2),
    .stall_o(st), .stall_count_o(cnt)
  );

  // ---------------- instance B (DEPTH=7) ----------------
  logic        rn_b;
  logic [C_DB*32-1:0] sd_b;
  logic [31:0] v1_b, v2_b;
  logic [2:0]  sel1_b, sel2_b;
  logic        st_b;
  logic [15:0] cnt_b;

  fwd_hazard_scoreboard #(.ADDR_W(5), .DATA_W(32), .DEPTH(C_DB), .LOAD_LAT(1), .SEL_W(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rn_b), .fwd_en_i(1'b0), .id_valid_i(1'b1),
    .id_src1_i(5'd6), .id_src2_i(5'd0), .id_uses_src2_i(1'b0), .id_dest_i(5'd6),
    .id_wb_en_i(1'b1), .id_is_load_i(1'b0), .flush_i(1'b0),
    .rf_val1_i(32'h0), .rf_val2_i(32'h0), .stage_data_i(sd_b),
    .val1_o(v1_b), .val2_o(v2_b), .val1_sel_o(sel1_b), .val2_sel_o(sel2_b),
    .stall_o(st_b), .stall_count_o(cnt_b)
  );

  typedef struct {
    logic       rn, fwd, vld;
    logic [4:0] s1, s2;
    logic       u2;
    logic [4:0] dst;
    logic       wb, ld, fl;
    logic [2:0] e1, e2;
    logic       est;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tv [19];
  int checks   = 0;
  int failures = 0;
  int row      = 0;

  function automatic vec_t mk(logic rn_, fwd_, vld_, logic [4:0] s1_, s2_, logic u2_,
                              logic [4:0] dst_, logic wb_, ld_, fl_,
                              logic [2:0] e1_, e2_, logic est_, logic [15:0] ecnt_);
    vec_t v;
    v.rn = rn_; v.fwd = fwd_; v.vld = vld_; v.s1 = s1_; v.s2 = s2_; v.u2 = u2_;
    v.dst = dst_; v.wb = wb_; v.ld = ld_; v.fl = fl_;
    v.e1 = e1_; v.e2 = e2_; v.est = est_; v.ecnt = ecnt_;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_val(logic [2:0] s, logic [31:0] rf);
    int k;
    if (s == 3'd0) return rf;
    k = int'(s) - 1;
    return sd_a[k*32 +: 32];
  endfunction

  initial begin
    int nstall;
    int cyc;

    //             rn fwd vld s1  s2  u2 dst wb ld fl | e1 e2 st cnt
    tv[0]  = mk(0, 1, 1, 3,  3,  1, 3,  1, 0, 0,  0, 0, 0, 0);
    tv[1]  = mk(1, 1, 1, 1,  2,  1, 3,  1, 0, 0,  0, 0, 0, 0); // ADD r3
    tv[2]  = mk(1, 1, 1, 3,  0,  1, 4,  1, 0, 0,  1, 0, 0, 0); // read r3 from EXE
    tv[3]  = mk(1, 1, 1, 4,  3,  1, 4,  1, 0, 0,  1, 2, 0, 0); // r4 EXE, r3 MEM
    tv[4]  = mk(1, 1, 1, 4,  3,  0, 0,  1, 1, 0,  1, 0, 0, 0); // r4 EXE+MEM, src2 unused
    tv[5]  = mk(1, 1, 1, 0,  4,  1, 5,  1, 1, 0,  0, 2, 0, 0); // r0 writer ignored
    tv[6]  = mk(1, 1, 1, 5,  0,  0, 6,  1, 0, 0,  0, 0, 1, 0); // load-use stall
    tv[7]  = mk(1, 1, 1, 5,  0,  0, 6,  1, 0, 0,  2, 0, 0, 1); // then forward MEM
    tv[8]  = mk(1, 0, 1, 6,  0,  0, 7,  1, 0, 0,  0, 0, 1, 1); // fwd off: 3 stalls
    tv[9]  = mk(1, 0, 1, 6,  0,  0, 7,  1, 0, 0,  0, 0, 1, 2);
    tv[10] = mk(1, 0, 1, 6,  0,  0, 7,  1, 0, 0,  0, 0, 1, 3);
    tv[11] = mk(1, 0, 1, 6,  0,  0, 7,  1, 0, 0,  0, 0, 0, 4);
    tv[12] = mk(1, 0, 1, 7,  0,  0, 8,  1, 0, 1,  0, 0, 0, 4); // flush kills stall
    tv[13] = mk(1, 1, 1, 8,  7,  1, 9,  1, 1, 0,  0, 2, 0, 4); // r8 never entered
    tv[14] = mk(1, 0, 1, 9,  0,  0, 10, 1, 0, 0,  0, 0, 1, 4); // stall ...
    tv[15] = mk(0, 0, 1, 9,  0,  0, 10, 1, 0, 0,  0, 0, 0, 5); // ... reset mid-stall
    tv[16] = mk(1, 0, 1, 9,  0,  0, 10, 1, 0, 0,  0, 0, 0, 0); // hazard dropped
    tv[17] = mk(1, 0, 0, 10, 0,  0, 11, 1, 0, 0,  0, 0, 0, 0); // no stall without valid
    tv[18] = mk(1, 1, 1, 10, 0,  1, 0,  0, 0, 0,  2, 0, 0, 0); // r10 now in MEM

    for (int i = 0; i < C_DA; i++) sd_a[i*32 +: 32] = 32'h1111_0000 + 32'(i);
    for (int i = 0; i < C_DB; i++) sd_b[i*32 +: 32] = 32'h2222_0000 + 32'(i);
    rf1 = 32'hAAAA_0001;
    rf2 = 32'hBBBB_0002;
    rn = 1'b0; rn_b = 1'b0;
    fwd = 1'b1; vld = 1'b0; s1 = '0; s2 = '0; u2 = 1'b0; dst = '0;
    wb = 1'b0; ld = 1'b0; fl = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      row = i;
      rn = tv[i].rn; fwd = tv[i].fwd; vld = tv[i].vld; s1 = tv[i].s1; s2 = tv[i].s2;
      u2 = tv[i].u2; dst = tv[i].dst; wb = tv[i].wb; ld = tv[i].ld; fl = tv[i].fl;
      #1;
      chk("val1_sel", 32'(sel1), 32'(tv[i].e1));
      chk("val2_sel", 32'(sel2), 32'(tv[i].e2));
      chk("val1", v1, exp_val(tv[i].e1, rf1));
      chk("val2", v2, exp_val(tv[i].e2, rf2));
      chk("stall", 32'(st), 32'(tv[i].est));
      chk("stall_count", 32'(cnt), 32'(tv[i].ecnt));
    end

    // Saturation: self-dependent writer with forwarding off stalls 7 of 8 cycles
    row = 100;
    @(negedge clk);
    rn_b = 1'b1;
    nstall = 0;
    cyc = 0;
    while (nstall < 66100 && cyc < 90000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) chk("sat_early_count", 32'(cnt_b), 32'(nstall));
      if (st_b) nstall++;
    end
    chk("sat_budget", 32'(nstall >= 66100), 32'd1);
    @(negedge clk);
    chk("sat_count", 32'(cnt_b), 32'h0000_FFFF);
    repeat (20) @(negedge clk);
    chk("sat_hold", 32'(cnt_b), 32'h0000_FFFF);
    chk("sat_sel", 32'(sel1_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
